// File: rtl/euclid_array_if.sv
// Avalon-MM slave bus bundle for euclid_array.
// Handshake: no backpressure. slave_waitrequest is held 0, so every asserted
// slave_read or slave_write is accepted on the clock edge it is sampled on, and
// slave_readdata is valid exactly one cycle after the accepted slave_read.
interface euclid_array_if #(
    parameter int ADDRESS_WIDTH = 5
);
    logic [ADDRESS_WIDTH-1:0] slave_address;
    logic                     slave_read;
    logic [31:0]              slave_readdata;
    logic                     slave_write;
    logic [31:0]              slave_writedata;
    logic                     slave_waitrequest;

    modport master (
        output slave_address, slave_read, slave_write, slave_writedata,
        input  slave_readdata, slave_waitrequest
    );

    modport slave (
        input  slave_address, slave_read, slave_write, slave_writedata,
        output slave_readdata, slave_waitrequest
    );
endinterface

// File: rtl/euclid_array.sv
// euclid_array: NUM_CH-channel Euclidean distance engine behind an Avalon-MM
// register file. One shared datapath walks the channels in turn.
// Optional macro EUCLID_SQUARED_EN: skip the square root and store dx^2+dy^2.
// dbg_state exposes the FSM state encoding (state_t) for observation.
module euclid_array #(
    parameter int NUM_CH        = 4,
    parameter int COORD_W       = 16,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic           clk,
    input  logic           rst,
    euclid_array_if.slave  bus,
    output logic           done_irq,
    output logic [2:0]     dbg_state
);
    localparam int D_W    = COORD_W + 1;
    localparam int SUM_W  = 2 * COORD_W + 2;
    localparam int ROOT_W = COORD_W + 1;
    localparam int REM_W  = COORD_W + 6;
    localparam int RI_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [31:0] RES_BASE = 32'(2 + 4 * NUM_CH);
    localparam logic [31:0] RES_END  = 32'(2 + 5 * NUM_CH);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SQUARE, S_SQRT, S_STORE} state_t;
    state_t state_q, state_d;

    // Register file
    logic [31:0]      coord_q  [NUM_CH][4];
    logic [31:0]      result_q [NUM_CH];
    logic [4:0]       count_q;
    logic [RI_W-1:0]  ch_q;
    logic             busy_q, done_q, irq_en_q, err_q;
    logic [31:0]      readdata_q;

    // Datapath
    logic [D_W-1:0]   dx_q, dy_q;
    logic [SUM_W-1:0] sum_q;
    logic [31:0]      res_val;

    // Bus decode
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [31:0]              addr_w, coord_off, rd_val;
    logic                     is_ctrl, is_count, is_coord, is_result;
    logic [RI_W-1:0]          coord_ch, res_sel;
    logic [1:0]               coord_j;
    logic                     wr, start_go, store_en, last_ch;

    assign addr = bus.slave_address;
    assign wr   = bus.slave_write;
    assign bus.slave_waitrequest = 1'b0;
    assign bus.slave_readdata    = readdata_q;
    assign done_irq  = done_q & irq_en_q;
    assign dbg_state = state_q;

    // Address decode and read mux
    always_comb begin
        addr_w    = 32'(addr);
        coord_off = addr_w - 32'd2;
        is_ctrl   = (addr_w == 32'd0);
        is_count  = (addr_w == 32'd1);
        is_coord  = (addr_w >= 32'd2) && (addr_w < RES_BASE);
        is_result = (addr_w >= RES_BASE) && (addr_w < RES_END);
        coord_ch  = RI_W'(coord_off >> 2);
        coord_j   = coord_off[1:0];
        res_sel   = RI_W'(addr_w - RES_BASE);
        rd_val    = '0;
        if (is_ctrl)        rd_val = {27'd0, err_q, irq_en_q, done_q, busy_q, 1'b0};
        else if (is_count)  rd_val = 32'(count_q);
        else if (is_coord)  rd_val = coord_q[coord_ch][coord_j];
        else if (is_result) rd_val = result_q[res_sel];
    end

    // Current-channel absolute differences and squared sum
    logic signed [COORD_W+1:0] x1_s, x2_s, y1_s, y2_s, ddx, ddy, adx, ady;
    logic [SUM_W-1:0]          dx_e, dy_e, sum_n;
    always_comb begin
        x1_s = (COORD_W+2)'(signed'(coord_q[ch_q][0][COORD_W-1:0]));
        x2_s = (COORD_W+2)'(signed'(coord_q[ch_q][1][COORD_W-1:0]));
        y1_s = (COORD_W+2)'(signed'(coord_q[ch_q][2][COORD_W-1:0]));
        y2_s = (COORD_W+2)'(signed'(coord_q[ch_q][3][COORD_W-1:0]));
        ddx  = x1_s - x2_s;
        ddy  = y1_s - y2_s;
        adx  = ddx[COORD_W+1] ? -ddx : ddx;
        ady  = ddy[COORD_W+1] ? -ddy : ddy;
        dx_e = SUM_W'(dx_q);
        dy_e = SUM_W'(dy_q);
        sum_n = dx_e * dx_e + dy_e * dy_e;
    end

`ifndef EUCLID_SQUARED_EN
    // Non-restoring square root: remainder kept in two's complement, one
    // root bit per step decided by the sign of the new remainder.
    logic [REM_W-1:0]  rem_q, rem_sh, rem_n;
    logic [ROOT_W-1:0] root_q, root_n;
    logic [4:0]        sqrt_cnt_q;
    logic              sqrt_last;
    always_comb begin
        rem_sh = {rem_q[REM_W-3:0], sum_q[SUM_W-1 -: 2]};
        if (!rem_q[REM_W-1]) rem_n = rem_sh - REM_W'({root_q, 2'b01});
        else                 rem_n = rem_sh + REM_W'({root_q, 2'b11});
        root_n    = {root_q[ROOT_W-2:0], ~rem_n[REM_W-1]};
        sqrt_last = (sqrt_cnt_q == 5'(ROOT_W - 1));
        res_val   = 32'(root_q);
    end
`else
    logic [63:0] sum_wide;
    always_comb begin
        sum_wide = 64'(sum_q);
        res_val  = sum_wide[31:0];
    end
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // FSM next state and control strobes
    always_comb begin
        state_d  = state_q;
        start_go = 1'b0;
        store_en = 1'b0;
        last_ch  = (ch_q == RI_W'(NUM_CH - 1));
        case (state_q)
            S_IDLE: if (wr && is_ctrl && bus.slave_writedata[0]) begin
                start_go = 1'b1;
                state_d  = S_LOAD;
            end
            S_LOAD: state_d = S_SQUARE;
`ifdef EUCLID_SQUARED_EN
            S_SQUARE: state_d = S_STORE;
`else
            S_SQUARE: state_d = S_SQRT;
            S_SQRT:   if (sqrt_last) state_d = S_STORE;
`endif
            S_STORE: begin
                store_en = 1'b1;
                state_d  = last_ch ? S_IDLE : S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath pipeline registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dx_q  <= '0;
            dy_q  <= '0;
            sum_q <= '0;
`ifndef EUCLID_SQUARED_EN
            rem_q      <= '0;
            root_q     <= '0;
            sqrt_cnt_q <= '0;
`endif
        end else begin
            if (state_q == S_LOAD) begin
                dx_q <= adx[D_W-1:0];
                dy_q <= ady[D_W-1:0];
            end
            if (state_q == S_SQUARE) begin
                sum_q <= sum_n;
`ifndef EUCLID_SQUARED_EN
                rem_q      <= '0;
                root_q     <= '0;
                sqrt_cnt_q <= '0;
`endif
            end
`ifndef EUCLID_SQUARED_EN
            if (state_q == S_SQRT) begin
                sum_q      <= sum_q << 2;
                rem_q      <= rem_n;
                root_q     <= root_n;
                sqrt_cnt_q <= sqrt_cnt_q + 5'd1;
            end
`endif
        end
    end

    // Register file writes; hardware sets come last so they win over W1C
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                result_q[c] <= '0;
                for (int j = 0; j < 4; j++) coord_q[c][j] <= '0;
            end
            count_q  <= '0;
            ch_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            irq_en_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (wr && is_ctrl) begin
                irq_en_q <= bus.slave_writedata[3];
                if (bus.slave_writedata[2]) done_q <= 1'b0;
                if (bus.slave_writedata[4]) err_q  <= 1'b0;
                if (bus.slave_writedata[0] && busy_q) err_q <= 1'b1;
            end
            if (wr && is_coord) begin
                if (busy_q) err_q <= 1'b1;
                else        coord_q[coord_ch][coord_j] <= bus.slave_writedata;
            end
            if (wr && is_result && busy_q) err_q <= 1'b1;
            if (start_go) begin
                for (int c = 0; c < NUM_CH; c++) result_q[c] <= '0;
                count_q <= '0;
                ch_q    <= '0;
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
            end
            if (store_en) begin
                result_q[ch_q] <= res_val;
                count_q        <= count_q + 5'd1;
                if (last_ch) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    ch_q <= ch_q + RI_W'(1);
                end
            end
        end
    end

    // Read data register, one cycle behind slave_read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 readdata_q <= '0;
        else if (bus.slave_read)  readdata_q <= rd_val;
        else                      readdata_q <= '0;
    end
endmodule

// File: doc/euclid_array.md
Name: euclid_array

Overview:
- Parametrised successor to the single-shot distance accelerator.
- Avalon-MM slave register file holding NUM_CH coordinate pairs. A single shared datapath computes floor(sqrt((x1-x2)^2 + (y1-y2)^2)) for each channel in turn, writes per-channel result registers, then raises a maskable done interrupt.
- Sits on the Nios/HPS Avalon bus beside the pathfinding software, which batch-loads node pairs and collects distances.

Parameters:
- NUM_CH, 4: number of distance channels, range 1..16.
- COORD_W, 16: signed coordinate width taken from bits [COORD_W-1:0] of each coordinate word, range 2..16.
- ADDRESS_WIDTH, 5: word address width; must satisfy 2^ADDRESS_WIDTH >= 2+5*NUM_CH.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- slave_address  in  ADDRESS_WIDTH  word address
- slave_read  in  1  read strobe
- slave_readdata  out  32  read data, valid the cycle after slave_read (read latency 1)
- slave_write  in  1  write strobe
- slave_writedata  in  32  write data
- slave_waitrequest  out  1  tied 0
- done_irq  out  1  interrupt, level, = DONE & IRQ_EN

Behaviour:
- Register map (word addresses):
  - 0 CTRL: [0] START (write-1, reads 0), [1] BUSY (RO), [2] DONE (sticky, write-1-clear), [3] IRQ_EN (RW), [4] ERR (sticky, write-1-clear).
  - 1 COUNT (RO): channels completed in the current/last run.
  - 2+4k..5+4k: x1, x2, y1, y2 of channel k (RW).
  - 2+4*NUM_CH+k: RESULT k (RO).
  - Unmapped reads return 0; unmapped writes are ignored.
- Reset (rst=0, async):
  - All registers 0; FSM in IDLE.
  - slave_readdata=0, done_irq=0, slave_waitrequest=0.
- FSM states: IDLE, LOAD, SQUARE, SQRT, STORE.
  - IDLE: a write with CTRL[0]=1 goes to LOAD next cycle, with channel index=0, COUNT=0, all RESULT=0, DONE=0, BUSY=1. Other CTRL bits in the same write apply as normal; IRQ_EN takes the written value.
  - LOAD (1 cycle): sign-extend coordinates and register |x1-x2| and |y1-y2| (COORD_W+1 bits each).
  - SQUARE (1 cycle): register sum = dx^2+dy^2, SUM_W = 2*COORD_W+2 bits, no truncation.
  - SQRT (COORD_W+1 cycles): non-restoring bit-pair integer square root, 2 sum bits per cycle, result COORD_W+1 bits.
  - STORE (1 cycle): RESULT[k] = root zero-extended to 32 bits; COUNT increments. If k==NUM_CH-1, go to IDLE with BUSY=0 and DONE=1; else k++ and go to LOAD.
- Latency: START write edge to DONE=1 is exactly NUM_CH*(COORD_W+4) cycles. Default: 80.
- Writes while BUSY:
  - Writes to coordinate or RESULT addresses are dropped and set ERR.
  - A CTRL write with START=1 is ignored for START and sets ERR; DONE/ERR clears and IRQ_EN are honoured.
  - Writes to RESULT while IDLE are ignored, no ERR.
- Simultaneous hardware DONE set and software W1C of DONE in the same cycle: set wins.
- Reads during BUSY are allowed. RESULT registers of unfinished channels read 0.
- Reset asserted mid-run aborts immediately; all state returns to reset values.
- Equal points give result 0. Max magnitude is floor(sqrt(2)*2^COORD_W), which fits COORD_W+1 bits.

Optional Feature:
- Macro: EUCLID_SQUARED_EN.
- Defined: SQRT state removed. STORE writes the squared sum (SUM_W bits, zero-extended, truncated to 32 if wider). Per-channel latency is 3 cycles; START-to-DONE is NUM_CH*3.
- Undefined: full square root as above.

Test Plan:
- Reset mid-run: assert rst during SQRT of channel 1 -> CTRL=0, COUNT=0, RESULT all 0, done_irq=0 immediately; a new START completes normally.
- Basic: ch0 (0,3)-(0,4) i.e. x1=0,x2=3,y1=0,y2=4; ch1 x1=-5,x2=7,y1=2,y2=-3; ch2,ch3 all 0; IRQ_EN=1, START -> after 80 cycles DONE=1, done_irq=1, RESULT0=5, RESULT1=13, RESULT2=RESULT3=0, COUNT=4.
- Rounding/extremes: x1=-32768, x2=32767, y1=-32768, y2=32767 -> RESULT=92680 (floor of 65535*sqrt2); x1=1,y1=1, others 0 -> RESULT=1.
- Busy protection: START, then write ch0 x1 and START again at cycle 10 -> ERR=1, x1 unchanged, run finishes at cycle 80; W1C ERR -> ERR=0.
- IRQ handling: IRQ_EN=0 run -> DONE=1, done_irq=0; set IRQ_EN -> done_irq=1; write CTRL=0x4 -> DONE=0, done_irq=0. Same-cycle W1C at completion -> DONE stays 1.
- Bus protocol: read unmapped address 31 -> 0 one cycle later; slave_waitrequest always 0. With EUCLID_SQUARED_EN, basic test -> RESULT0=25, RESULT1=169, DONE at cycle 12.
